// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor
//   Computes A - B one bit per clock, LSB first, using one full-subtractor cell
//   and a registered borrow. Operands arrive on a valid/ready start handshake.
//   The result leaves on a valid/ready result handshake.
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_start_valid    operands valid, request a subtraction
//   o_start_ready    operands can be accepted (IDLE only)
//   i_a_in           minuend, sampled on the start handshake
//   i_b_in           subtrahend, sampled on the start handshake
//   o_result_valid   o_diff_out/o_borrow_out valid (DONE only)
//   i_result_ready   consumer accepts the result
//   o_diff_out       (a - b) mod 2^WIDTH
//   o_borrow_out     final borrow, 1 iff a < b (unsigned)
//   o_busy           high while bits are being processed
//   o_bit_diff       difference bit produced on the most recent RUN edge
module bit_serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [WIDTH-1:0] i_a_in,
    input  logic [WIDTH-1:0] i_b_in,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic [WIDTH-1:0] o_diff_out,
    output logic             o_borrow_out,
    output logic             o_busy,
    output logic             o_bit_diff
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [CntW-1:0]  r_count;
    logic [WIDTH-1:0] r_diff_out;
    logic             r_borrow_out;
    logic             r_bit_diff;

    // Full-subtractor cell on the operand LSBs.
    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_last;

    assign w_a0        = r_a[0];
    assign w_b0        = r_b[0];
    assign w_d         = w_a0 ^ w_b0 ^ r_borrow;
    assign w_br_next   = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign w_diff_next = {w_d, r_diff[WIDTH-1:1]};
    assign w_last      = (r_count == CntW'(WIDTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_a          <= '0;
            r_b          <= '0;
            r_diff       <= '0;
            r_borrow     <= 1'b0;
            r_count      <= '0;
            r_diff_out   <= '0;
            r_borrow_out <= 1'b0;
            r_bit_diff   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start_valid) begin
                        r_a      <= i_a_in;
                        r_b      <= i_b_in;
                        r_diff   <= '0;
                        r_borrow <= 1'b0;
                        r_count  <= '0;
                        r_state  <= StRun;
                    end
                end
                StRun: begin
                    r_a        <= r_a >> 1;
                    r_b        <= r_b >> 1;
                    r_diff     <= w_diff_next;
                    r_borrow   <= w_br_next;
                    r_bit_diff <= w_d;
                    r_count    <= r_count + CntW'(1);
                    if (w_last) begin
                        r_diff_out   <= w_diff_next;
                        r_borrow_out <= w_br_next;
                        r_state      <= StDone;
                    end
                end
                StDone: begin
                    // A start presented alongside result_ready is not taken
                    // here; it is accepted from IDLE on a later edge.
                    if (i_result_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_start_ready  = (r_state == StIdle);
    assign o_busy         = (r_state == StRun);
    assign o_result_valid = (r_state == StDone);
    assign o_diff_out     = r_diff_out;
    assign o_borrow_out   = r_borrow_out;
    assign o_bit_diff     = r_bit_diff;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb_bit_serial_subtractor
//   Scoreboard bench: stimulus pushes expected results (value and due cycle)
//   into a queue; a monitor per DUT pops and compares on each result handshake.
//   An 8-bit instance covers directed cases; a 3-bit instance is swept fully.
module tb_bit_serial_subtractor;

    typedef struct {
        logic [7:0]  diff;
        logic        borrow;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit instance
    logic       rst8_n, sv8, sr8, rv8, rr8, bo8, busy8, bd8;
    logic [7:0] a8, b8, d8;
    // 3-bit instance
    logic       rst3_n, sv3, sr3, rv3, rr3, bo3, busy3, bd3;
    logic [2:0] a3, b3, d3;

    exp_t q8[$];
    exp_t q3[$];

    bit_serial_subtractor #(.WIDTH(8)) u_dut8 (
        .i_clk          (clk),
        .i_rst_n        (rst8_n),
        .i_start_valid  (sv8),
        .o_start_ready  (sr8),
        .i_a_in         (a8),
        .i_b_in         (b8),
        .o_result_valid (rv8),
        .i_result_ready (rr8),
        .o_diff_out     (d8),
        .o_borrow_out   (bo8),
        .o_busy         (busy8),
        .o_bit_diff     (bd8)
    );

    bit_serial_subtractor #(.WIDTH(3)) u_dut3 (
        .i_clk          (clk),
        .i_rst_n        (rst3_n),
        .i_start_valid  (sv3),
        .o_start_ready  (sr3),
        .i_a_in         (a3),
        .i_b_in         (b3),
        .o_result_valid (rv3),
        .i_result_ready (rr3),
        .o_diff_out     (d3),
        .o_borrow_out   (bo3),
        .o_busy         (busy3),
        .o_bit_diff     (bd3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitors sample on the falling edge; inputs only change #1 after rising edges.
    logic pv8 = 1'b0;
    always @(negedge clk) begin
        if (rv8 && !pv8) begin
            if (q8.size() == 0) check("w8 unexpected result_valid", 32'd1, 32'd0);
            else check("w8 latency (cycle of result_valid)", cyc, q8[0].due);
        end
        if (rv8 && rr8 && q8.size() != 0) begin
            check("w8 diff_out", {24'd0, d8}, {24'd0, q8[0].diff});
            check("w8 borrow_out", {31'd0, bo8}, {31'd0, q8[0].borrow});
            void'(q8.pop_front());
        end
        pv8 = rv8;
    end

    logic pv3 = 1'b0;
    always @(negedge clk) begin
        if (rv3 && !pv3) begin
            if (q3.size() == 0) check("w3 unexpected result_valid", 32'd1, 32'd0);
            else check("w3 latency (cycle of result_valid)", cyc, q3[0].due);
        end
        if (rv3 && rr3 && q3.size() != 0) begin
            check("w3 diff_out", {29'd0, d3}, {29'd0, q3[0].diff[2:0]});
            check("w3 borrow_out", {31'd0, bo3}, {31'd0, q3[0].borrow});
            void'(q3.pop_front());
        end
        pv3 = rv3;
    end

    // Issue one 8-bit op; returns #1 after the accepting edge (or after the bit walk).
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                       input logic eb, input bit chk_bits, input bit push,
                       output int unsigned acc);
        int unsigned n;
        n = 0;
        acc = 0;
        @(posedge clk); #1;
        while (!sr8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sr8) begin
            check("w8 start_ready timeout", 32'd0, 32'd1);
            return;
        end
        sv8 = 1'b1; a8 = a; b8 = b;
        acc = cyc + 1;
        if (push) q8.push_back('{diff: ed, borrow: eb, due: acc + 8});
        @(posedge clk); #1;
        sv8 = 1'b0;
        if (chk_bits) begin
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                @(negedge clk);
                check($sformatf("w8 bit_diff[%0d]", i), {31'd0, bd8}, {31'd0, ed[i]});
                if (i < 7) check("w8 busy in RUN", {31'd0, busy8}, 32'd1);
            end
        end
    endtask

    task automatic op3(input logic [2:0] a, input logic [2:0] b, output int unsigned acc);
        int unsigned n;
        logic [2:0]  ed;
        n = 0;
        acc = 0;
        @(posedge clk); #1;
        while (!sr3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sr3) begin
            check("w3 start_ready timeout", 32'd0, 32'd1);
            return;
        end
        sv3 = 1'b1; a3 = a; b3 = b;
        acc = cyc + 1;
        ed = a - b;
        q3.push_back('{diff: {5'd0, ed}, borrow: (a < b), due: acc + 3});
        @(posedge clk); #1;
        sv3 = 1'b0;
    endtask

    initial begin
        int unsigned acc;
        int unsigned last_acc;
        int unsigned n;

        rst8_n = 1'b0; rst3_n = 1'b0;
        sv8 = 1'b0; a8 = '0; b8 = '0; rr8 = 1'b1;
        sv3 = 1'b0; a3 = '0; b3 = '0; rr3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset start_ready", {31'd0, sr8}, 32'd1);
        check("reset result_valid", {31'd0, rv8}, 32'd0);
        check("reset busy", {31'd0, busy8}, 32'd0);
        check("reset diff_out", {24'd0, d8}, 32'd0);
        check("reset borrow_out", {31'd0, bo8}, 32'd0);
        check("reset bit_diff", {31'd0, bd8}, 32'd0);
        rst8_n = 1'b1; rst3_n = 1'b1;

        // Basic cases, with the serial bit stream checked.
        op8(8'd100, 8'd37, 8'd63, 1'b0, 1'b1, 1'b1, acc);
        op8(8'h00, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b1, acc);
        op8(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1, acc);
        op8(8'b0000_0001, 8'b0000_0010, 8'hFF, 1'b1, 1'b1, 1'b1, acc);

        // Backpressure and ignored starts.
        @(posedge clk); #1;
        rr8 = 1'b0;
        op8(8'd200, 8'd50, 8'd150, 1'b0, 1'b0, 1'b1, acc);
        sv8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(negedge clk);
        check("start_ready low in RUN", {31'd0, sr8}, 32'd0);
        check("busy high in RUN", {31'd0, busy8}, 32'd1);
        @(posedge clk); #1;
        sv8 = 1'b0;
        n = 0;
        while (!rv8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("result_valid reached under backpressure", {31'd0, rv8}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            sv8 = i[0]; a8 = 8'hF0; b8 = 8'h0F;
            @(negedge clk);
            check("held result_valid", {31'd0, rv8}, 32'd1);
            check("held diff_out", {24'd0, d8}, 32'd150);
            check("held borrow_out", {31'd0, bo8}, 32'd0);
            check("start_ready low in DONE", {31'd0, sr8}, 32'd0);
            @(posedge clk); #1;
        end
        // result_ready with start_valid in DONE: only return to IDLE.
        sv8 = 1'b1; rr8 = 1'b1;
        @(posedge clk); #1;
        sv8 = 1'b0;
        @(negedge clk);
        check("start with ready in DONE not accepted", {31'd0, sr8}, 32'd1);
        check("busy low after DONE exit", {31'd0, busy8}, 32'd0);
        check("diff_out kept in IDLE", {24'd0, d8}, 32'd150);

        // Reset abort at RUN count=3.
        op8(8'hC3, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        rst8_n = 1'b0;
        #1;
        check("abort start_ready", {31'd0, sr8}, 32'd1);
        check("abort result_valid", {31'd0, rv8}, 32'd0);
        check("abort busy", {31'd0, busy8}, 32'd0);
        check("abort diff_out", {24'd0, d8}, 32'd0);
        check("abort borrow_out", {31'd0, bo8}, 32'd0);
        check("abort bit_diff", {31'd0, bd8}, 32'd0);
        @(negedge clk);
        rst8_n = 1'b1;
        op8(8'd9, 8'd4, 8'd5, 1'b0, 1'b0, 1'b1, acc);

        // Exhaustive 3-bit sweep with back-to-back spacing.
        last_acc = 0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                op3(a[2:0], b[2:0], acc);
                if (!(a == 0 && b == 0)) check("w3 op spacing", acc - last_acc, 32'd5);
                last_acc = acc;
            end
        end

        n = 0;
        while ((q8.size() != 0 || q3.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("w8 scoreboard drained", q8.size(), 32'd0);
        check("w3 scoreboard drained", q3.size(), 32'd0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
